// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: execute-stage unit combining the base integer ALU with an
// iterative multiply/divide engine behind a valid/ready handshake.
// Base ops and divide special cases finish in one cycle. Mul/div take XLEN
// shift-add or restoring steps. All outputs are registered.
module alu_muldiv_seq #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_muldiv,
    input  logic [3:0]      ALUSel,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state;
    logic [2*XLEN-1:0] p;       // mul: {hi, multiplier/lo}; div: {rem, dividend/quotient}
    logic [XLEN-1:0]   m;       // multiplicand or divisor magnitude
    logic [2:0]        op;
    logic              neg;     // final result must be negated
    logic [CW-1:0]     cnt;

    // Base ALU, evaluated directly on the request inputs
    logic [XLEN-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (ALUSel)
            4'd0:  alu_res = op_a + op_b;
            4'd1:  alu_res = op_a - op_b;
            4'd2:  alu_res = op_a & op_b;
            4'd3:  alu_res = op_a | op_b;
            4'd4:  alu_res = op_a ^ op_b;
            4'd5:  alu_res = op_a << op_b[SHAMT_W-1:0];
            4'd6:  alu_res = op_a >> op_b[SHAMT_W-1:0];
            4'd7:  alu_res = $signed(op_a) >>> op_b[SHAMT_W-1:0];
            4'd8:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd9:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'd10: alu_res = op_a + (op_b << 12);
            4'd11: alu_res = op_b << 12;
            default: alu_res = '0;
        endcase
    end

    // Request decode for mul/div: operand signs, magnitudes and special cases
    logic            sgn_a, sgn_b, sa, sb, div_zero, div_ovf, special, acc_neg;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;
    always_comb begin
        sgn_a    = (md_op != 3'd3) && (md_op != 3'd5) && (md_op != 3'd7);
        sgn_b    = (md_op == 3'd0) || (md_op == 3'd1) || (md_op == 3'd4) || (md_op == 3'd6);
        sa       = sgn_a & op_a[XLEN-1];
        sb       = sgn_b & op_b[XLEN-1];
        mag_a    = sa ? -op_a : op_a;
        mag_b    = sb ? -op_b : op_b;
        // Remainder follows the dividend sign; everything else follows the sign product
        acc_neg  = (md_op[2] & md_op[1]) ? sa : (sa ^ sb);
        div_zero = md_op[2] && (op_b == '0);
        div_ovf  = ((md_op == 3'd4) || (md_op == 3'd6)) &&
                   (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special  = div_zero | div_ovf;
        spec_res = '0;
        if (div_zero)
            spec_res = md_op[1] ? op_a : '1;
        else if (div_ovf)
            spec_res = md_op[1] ? '0 : op_a;
    end

    // One iteration step plus the sign-corrected result taken from it
    logic [XLEN:0]     sum, shifted, diff;
    logic              ge;
    logic [2*XLEN-1:0] p_nxt, mul_s;
    logic [XLEN-1:0]   sel_d, div_s, md_fin;
    always_comb begin
        sum     = {1'b0, p[2*XLEN-1:XLEN]} + {1'b0, (p[0] ? m : {XLEN{1'b0}})};
        shifted = p[2*XLEN-1:XLEN-1];
        diff    = shifted - {1'b0, m};
        ge      = ~diff[XLEN];
        if (op[2])
            p_nxt = {(ge ? diff[XLEN-1:0] : shifted[XLEN-1:0]), p[XLEN-2:0], ge};
        else
            p_nxt = {sum, p[XLEN-1:1]};
        mul_s  = neg ? -p_nxt : p_nxt;
        sel_d  = op[1] ? p_nxt[2*XLEN-1:XLEN] : p_nxt[XLEN-1:0];
        div_s  = neg ? -sel_d : sel_d;
        case (op)
            3'd0:                md_fin = mul_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    md_fin = mul_s[2*XLEN-1:XLEN];
            default:             md_fin = div_s;
        endcase
    end

    // Control FSM with registered handshake outputs and result
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            p         <= '0;
            m         <= '0;
            op        <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    out_valid <= 1'b0;
                    if (in_valid) begin
                        op  <= md_op;
                        neg <= acc_neg;
                        cnt <= '0;
                        m   <= md_op[2] ? mag_b : mag_a;
                        p   <= {{XLEN{1'b0}}, (md_op[2] ? mag_a : mag_b)};
                        in_ready <= 1'b0;
                        if (!is_muldiv || special) begin
                            result    <= is_muldiv ? spec_res : alu_res;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    p   <= p_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN-1)) begin
                        result    <= md_fin;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: vector table at XLEN=32, reset abort,
// held in_valid, and a 64-bit instance for wide multiply/divide.
module tb_alu_muldiv_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, is_muldiv, out_valid, busy;
    logic [3:0]  alusel;
    logic [2:0]  md_op;
    logic [31:0] op_a, op_b, result;

    logic        v64, r64, md64, ov64, b64;
    logic [3:0]  sel64;
    logic [2:0]  mop64;
    logic [63:0] a64, bb64, res64;

    alu_muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .is_muldiv(is_muldiv), .ALUSel(alusel), .md_op(md_op),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .result(result), .busy(busy)
    );

    alu_muldiv_seq #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64),
        .is_muldiv(md64), .ALUSel(sel64), .md_op(mop64),
        .op_a(a64), .op_b(bb64), .out_valid(ov64), .result(res64), .busy(b64)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        md;
        logic [3:0]  sel;
        logic [2:0]  mop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[$];

    // One transaction on the 32-bit unit; lat counts negedges after the accept edge
    task automatic run32(input vec_t v, output logic [31:0] res, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        is_muldiv = v.md; alusel = v.sel; md_op = v.mop; op_a = v.a; op_b = v.b;
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 200);
        if (!out_valid) lat = -1;
        res = result;
    endtask

    task automatic run64(input logic md, input logic [3:0] sel, input logic [2:0] mop,
                         input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!r64 && w < 100) begin @(negedge clk); w++; end
        md64 = md; sel64 = sel; mop64 = mop; a64 = a; bb64 = b;
        v64 = 1'b1;
        @(posedge clk); #1 v64 = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ov64 && lat < 300);
        if (!ov64) lat = -1;
        res = res64;
    endtask

    initial begin
        logic [31:0] r;
        logic [63:0] r6;
        int          lat, ov, nr, bc;
        vec_t        v;

        rst = 1'b1; in_valid = 1'b0; is_muldiv = 1'b0; alusel = '0; md_op = '0;
        op_a = '0; op_b = '0;
        v64 = 1'b0; md64 = 1'b0; sel64 = '0; mop64 = '0; a64 = '0; bb64 = '0;

        vt.push_back('{1'b0, 4'd0,  3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
        vt.push_back('{1'b0, 4'd1,  3'd0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1});
        vt.push_back('{1'b0, 4'd2,  3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1});
        vt.push_back('{1'b0, 4'd3,  3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1});
        vt.push_back('{1'b0, 4'd4,  3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1});
        vt.push_back('{1'b0, 4'd5,  3'd0, 32'h00000001, 32'h00000023, 32'h00000008, 1});
        vt.push_back('{1'b0, 4'd6,  3'd0, 32'h80000000, 32'h00000004, 32'h08000000, 1});
        vt.push_back('{1'b0, 4'd7,  3'd0, 32'h80000000, 32'h00000004, 32'hF8000000, 1});
        vt.push_back('{1'b0, 4'd8,  3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
        vt.push_back('{1'b0, 4'd9,  3'd0, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1});
        vt.push_back('{1'b0, 4'd10, 3'd0, 32'h00001000, 32'h00012345, 32'h12346000, 1});
        vt.push_back('{1'b0, 4'd11, 3'd0, 32'h55555555, 32'h000ABCDE, 32'hABCDE000, 1});
        vt.push_back('{1'b0, 4'd12, 3'd0, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1});
        vt.push_back('{1'b1, 4'd0,  3'd0, 32'h00000007, 32'h00000006, 32'h0000002A, 33});
        vt.push_back('{1'b1, 4'd0,  3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 33});
        vt.push_back('{1'b1, 4'd0,  3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33});
        vt.push_back('{1'b1, 4'd0,  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
        vt.push_back('{1'b1, 4'd0,  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        vt.push_back('{1'b1, 4'd0,  3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
        vt.push_back('{1'b1, 4'd0,  3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
        vt.push_back('{1'b1, 4'd0,  3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33});
        vt.push_back('{1'b1, 4'd0,  3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33});
        vt.push_back('{1'b1, 4'd0,  3'd5, 32'd100,      32'd7,        32'd14,       33});
        vt.push_back('{1'b1, 4'd0,  3'd7, 32'd100,      32'd7,        32'd2,        33});
        vt.push_back('{1'b1, 4'd0,  3'd5, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 33});
        vt.push_back('{1'b1, 4'd0,  3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vt.push_back('{1'b1, 4'd0,  3'd6, 32'd5,        32'd0,        32'd5,        1});
        vt.push_back('{1'b1, 4'd0,  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vt.push_back('{1'b1, 4'd0,  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});

        // Reset state while rst is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            run32(v, r, lat);
            chk($sformatf("vec%0d_result", i), {32'd0, r}, {32'd0, v.exp});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(v.lat));
        end

        // Reset during CALC of MUL 7*6 aborts it without a completion pulse
        @(negedge clk);
        is_muldiv = 1'b1; md_op = 3'd0; op_a = 32'd7; op_b = 32'd6; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_result", {32'd0, result}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        ov = 0;
        repeat (40) begin @(negedge clk); if (out_valid) ov++; end
        chk("abort_no_out_valid", 64'(ov), 64'd0);

        // in_valid held through CALC and DONE: one accept, ready low until IDLE
        @(negedge clk);
        is_muldiv = 1'b1; md_op = 3'd0; op_a = 32'd9; op_b = 32'd11; in_valid = 1'b1;
        ov = 0; nr = 0; bc = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid) ov++;
            if (!in_ready) nr++;
            if (busy) bc++;
            if (in_ready && ov > 0) break;
        end
        in_valid = 1'b0;
        chk("hold_out_valid_pulses", 64'(ov), 64'd1);
        chk("hold_not_ready_cycles", 64'(nr), 64'd33);
        chk("hold_busy_cycles", 64'(bc), 64'd32);
        chk("hold_result", {32'd0, result}, 64'd99);
        ov = 0;
        repeat (40) begin @(negedge clk); if (out_valid) ov++; end
        chk("hold_no_second_accept", 64'(ov), 64'd0);

        // Wide instance
        run64(1'b1, 4'd0, 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, r6, lat);
        chk("x64_mulhu_result", r6, 64'hFFFFFFFFFFFFFFFE);
        chk("x64_mulhu_latency", 64'(lat), 64'd65);
        run64(1'b1, 4'd0, 3'd1, 64'h8000000000000000, 64'h8000000000000000, r6, lat);
        chk("x64_mulh_result", r6, 64'h4000000000000000);
        run64(1'b1, 4'd0, 3'd5, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000010, r6, lat);
        chk("x64_divu_result", r6, 64'h0FFFFFFFFFFFFFFF);
        run64(1'b0, 4'd0, 3'd0, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000002, r6, lat);
        chk("x64_add_result", r6, 64'h0000000000000001);
        chk("x64_add_latency", 64'(lat), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
